// File: rtl/dispatch_queue_pkg.sv
// rtl/dispatch_queue_pkg.sv - opcodes, tag constants and RS class codes shared by the dispatch queue
package dispatch_queue_pkg;

  typedef enum logic [1:0] {
    CLS_ALU = 2'd0,
    CLS_BR  = 2'd1,
    CLS_LSB = 2'd2
  } rs_class_e;

  localparam int unsigned NULL_TAG = 0;

  // Branch ops occupy [OP_BEQ, OP_JALR], memory ops [OP_LB, OP_SW]; the rest go to the ALU
  localparam int unsigned OP_BEQ  = 3;
  localparam int unsigned OP_JALR = 10;
  localparam int unsigned OP_LB   = 11;
  localparam int unsigned OP_LW   = 13;
  localparam int unsigned OP_SW   = 18;
  localparam int unsigned OP_ADDI = 19;
  localparam int unsigned OP_ADD  = 29;

  function automatic rs_class_e op_class(input logic [31:0] op);
    if (op >= OP_BEQ && op <= OP_JALR) return CLS_BR;
    if (op >= OP_LB && op <= OP_SW) return CLS_LSB;
    return CLS_ALU;
  endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// rtl/dispatch_queue_if.sv - ID, CDB and reservation-station signals of the dispatch queue
interface dispatch_queue_if #(
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 4,
  parameter int OP_W      = 6,
  parameter int CDB_PORTS = 2
);
  logic                          id_valid, id_ready;
  logic [OP_W-1:0]               id_op;
  logic [DATA_W-1:0]             id_imm, id_pc;
  logic [TAG_W-1:0]              id_dest_tag;
  logic                          src1_valid, src2_valid;
  logic [DATA_W-1:0]             src1_data, src2_data;
  logic [TAG_W-1:0]              src1_tag, src2_tag;
  logic [CDB_PORTS-1:0]          cdb_valid;
  logic [CDB_PORTS*TAG_W-1:0]    cdb_tag;
  logic [CDB_PORTS*DATA_W-1:0]   cdb_data;
  logic                          alu_full, br_full, lsb_full;
  logic                          alu_enable, br_enable, lsb_enable;
  logic [OP_W-1:0]               out_op;
  logic [DATA_W-1:0]             out_imm, out_pc;
  logic [TAG_W-1:0]              out_dest_tag;
  logic                          out_reg1_valid, out_reg2_valid;
  logic [DATA_W-1:0]             out_reg1_data, out_reg2_data;
  logic [TAG_W-1:0]              out_reg1_tag, out_reg2_tag;

  modport master (
    output id_valid, id_op, id_imm, id_pc, id_dest_tag,
           src1_valid, src1_data, src1_tag, src2_valid, src2_data, src2_tag,
           cdb_valid, cdb_tag, cdb_data, alu_full, br_full, lsb_full,
    input  id_ready, alu_enable, br_enable, lsb_enable, out_op, out_imm, out_pc, out_dest_tag,
           out_reg1_valid, out_reg1_data, out_reg1_tag, out_reg2_valid, out_reg2_data, out_reg2_tag
  );

  modport slave (
    input  id_valid, id_op, id_imm, id_pc, id_dest_tag,
           src1_valid, src1_data, src1_tag, src2_valid, src2_data, src2_tag,
           cdb_valid, cdb_tag, cdb_data, alu_full, br_full, lsb_full,
    output id_ready, alu_enable, br_enable, lsb_enable, out_op, out_imm, out_pc, out_dest_tag,
           out_reg1_valid, out_reg1_data, out_reg1_tag, out_reg2_valid, out_reg2_data, out_reg2_tag
  );
endinterface

// File: rtl/dispatch_queue_operand_wakeup.sv
// rtl/dispatch_queue_operand_wakeup.sv - next value of one operand after snooping the CDB ports
module operand_wakeup
  import dispatch_queue_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 4,
  parameter int CDB_PORTS = 2
) (
  input  logic                        valid_i,
  input  logic [TAG_W-1:0]            tag_i,
  input  logic [DATA_W-1:0]           data_i,
  input  logic [CDB_PORTS-1:0]        cdb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0]  cdb_tag,
  input  logic [CDB_PORTS*DATA_W-1:0] cdb_data,
  output logic                        valid_o,
  output logic [TAG_W-1:0]            tag_o,
  output logic [DATA_W-1:0]           data_o
);
  logic              hit;
  logic [DATA_W-1:0] hit_data;

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    // Scan downwards so the lowest matching port is the one that sticks
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == tag_i)) begin
        hit      = 1'b1;
        hit_data = cdb_data[p*DATA_W +: DATA_W];
      end
    end
    valid_o = 1'b0;
    tag_o   = tag_i;
    data_o  = '0;
    if (valid_i) begin
      valid_o = 1'b1;
      tag_o   = '0;
      data_o  = data_i;
    end else if (hit && (tag_i != TAG_W'(NULL_TAG))) begin
      valid_o = 1'b1;
      tag_o   = '0;
      data_o  = hit_data;
    end
  end
endmodule

// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - in-order buffered dispatch from ID to the ALU/Branch/LSB reservation stations
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 4,
  parameter int OP_W      = 6,
  parameter int CDB_PORTS = 2
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            clear_in,
  dispatch_queue_if.slave dq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [OP_W-1:0]   op_q [DEPTH], op_d [DEPTH];
  logic [DATA_W-1:0] imm_q [DEPTH], imm_d [DEPTH], pc_q [DEPTH], pc_d [DEPTH];
  logic [TAG_W-1:0]  dest_q [DEPTH], dest_d [DEPTH];
  rs_class_e         cls_q [DEPTH], cls_d [DEPTH];
  logic [DEPTH-1:0]  v1_q, v1_d, v2_q, v2_d;
  logic [TAG_W-1:0]  t1_q [DEPTH], t1_d [DEPTH], t2_q [DEPTH], t2_d [DEPTH];
  logic [DATA_W-1:0] d1_q [DEPTH], d1_d [DEPTH], d2_q [DEPTH], d2_d [DEPTH];

  logic              alu_en_q, alu_en_d, br_en_q, br_en_d, lsb_en_q, lsb_en_d;
  logic [OP_W-1:0]   out_op_q, out_op_d;
  logic [DATA_W-1:0] out_imm_q, out_imm_d, out_pc_q, out_pc_d;
  logic [TAG_W-1:0]  out_dest_q, out_dest_d;
  logic              out_v1_q, out_v1_d, out_v2_q, out_v2_d;
  logic [TAG_W-1:0]  out_t1_q, out_t1_d, out_t2_q, out_t2_d;
  logic [DATA_W-1:0] out_d1_q, out_d1_d, out_d2_q, out_d2_d;

  logic              enq, issue, head_blocked;
  rs_class_e         head_cls;
  logic [DEPTH-1:0]  wi_v1, wi_v2, wo_v1, wo_v2;
  logic [TAG_W-1:0]  wi_t1 [DEPTH], wi_t2 [DEPTH], wo_t1 [DEPTH], wo_t2 [DEPTH];
  logic [DATA_W-1:0] wi_d1 [DEPTH], wi_d2 [DEPTH], wo_d1 [DEPTH], wo_d2 [DEPTH];
  logic              iss_v1, iss_v2;
  logic [TAG_W-1:0]  iss_t1, iss_t2;
  logic [DATA_W-1:0] iss_d1, iss_d2;

  assign dq.id_ready = rst_in && rdy_in && !clear_in && (count_q < CNT_W'(DEPTH));

  // The slot being written this cycle snoops with the incoming operands so a same-cycle broadcast is kept
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic load;
    assign load     = enq && (tail_q == PTR_W'(g));
    assign wi_v1[g] = load ? dq.src1_valid : v1_q[g];
    assign wi_t1[g] = load ? dq.src1_tag   : t1_q[g];
    assign wi_d1[g] = load ? dq.src1_data  : d1_q[g];
    assign wi_v2[g] = load ? dq.src2_valid : v2_q[g];
    assign wi_t2[g] = load ? dq.src2_tag   : t2_q[g];
    assign wi_d2[g] = load ? dq.src2_data  : d2_q[g];
    operand_wakeup #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CDB_PORTS(CDB_PORTS)) u_src1 (
      .valid_i(wi_v1[g]), .tag_i(wi_t1[g]), .data_i(wi_d1[g]), .cdb_valid(dq.cdb_valid),
      .cdb_tag(dq.cdb_tag), .cdb_data(dq.cdb_data), .valid_o(wo_v1[g]), .tag_o(wo_t1[g]), .data_o(wo_d1[g]));
    operand_wakeup #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CDB_PORTS(CDB_PORTS)) u_src2 (
      .valid_i(wi_v2[g]), .tag_i(wi_t2[g]), .data_i(wi_d2[g]), .cdb_valid(dq.cdb_valid),
      .cdb_tag(dq.cdb_tag), .cdb_data(dq.cdb_data), .valid_o(wo_v2[g]), .tag_o(wo_t2[g]), .data_o(wo_d2[g]));
  end

  operand_wakeup #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CDB_PORTS(CDB_PORTS)) u_iss1 (
    .valid_i(v1_q[head_q]), .tag_i(t1_q[head_q]), .data_i(d1_q[head_q]), .cdb_valid(dq.cdb_valid),
    .cdb_tag(dq.cdb_tag), .cdb_data(dq.cdb_data), .valid_o(iss_v1), .tag_o(iss_t1), .data_o(iss_d1));
  operand_wakeup #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CDB_PORTS(CDB_PORTS)) u_iss2 (
    .valid_i(v2_q[head_q]), .tag_i(t2_q[head_q]), .data_i(d2_q[head_q]), .cdb_valid(dq.cdb_valid),
    .cdb_tag(dq.cdb_tag), .cdb_data(dq.cdb_data), .valid_o(iss_v2), .tag_o(iss_t2), .data_o(iss_d2));

  always_comb begin
    head_cls = cls_q[head_q];
    case (head_cls)
      CLS_BR:  head_blocked = dq.br_full;
      CLS_LSB: head_blocked = dq.lsb_full;
      default: head_blocked = dq.alu_full;
    endcase
    enq   = rdy_in && dq.id_valid && dq.id_ready;
    issue = rdy_in && !clear_in && (count_q != '0) && !head_blocked;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq)   tail_d = tail_q + 1'b1;
      if (issue) head_d = head_q + 1'b1;
      if (enq && !issue)      count_d = count_q + 1'b1;
      else if (!enq && issue) count_d = count_q - 1'b1;
    end

    op_d = op_q; imm_d = imm_q; pc_d = pc_q; dest_d = dest_q; cls_d = cls_q;
    if (rdy_in) begin
      v1_d = wo_v1; t1_d = wo_t1; d1_d = wo_d1;
      v2_d = wo_v2; t2_d = wo_t2; d2_d = wo_d2;
    end else begin
      v1_d = v1_q; t1_d = t1_q; d1_d = d1_q;
      v2_d = v2_q; t2_d = t2_q; d2_d = d2_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (enq && (tail_q == PTR_W'(i))) begin
        op_d[i]   = dq.id_op;
        imm_d[i]  = dq.id_imm;
        pc_d[i]   = dq.id_pc;
        dest_d[i] = dq.id_dest_tag;
        cls_d[i]  = op_class(32'(dq.id_op));
      end
    end

    alu_en_d = 1'b0; br_en_d = 1'b0; lsb_en_d = 1'b0;
    out_op_d = out_op_q; out_imm_d = out_imm_q; out_pc_d = out_pc_q; out_dest_d = out_dest_q;
    out_v1_d = out_v1_q; out_t1_d = out_t1_q; out_d1_d = out_d1_q;
    out_v2_d = out_v2_q; out_t2_d = out_t2_q; out_d2_d = out_d2_q;
    if (issue) begin
      alu_en_d   = (head_cls == CLS_ALU);
      br_en_d    = (head_cls == CLS_BR);
      lsb_en_d   = (head_cls == CLS_LSB);
      out_op_d   = op_q[head_q];
      out_imm_d  = imm_q[head_q];
      out_pc_d   = pc_q[head_q];
      out_dest_d = dest_q[head_q];
      out_v1_d = iss_v1; out_t1_d = iss_t1; out_d1_d = iss_d1;
      out_v2_d = iss_v2; out_t2_d = iss_t2; out_d2_d = iss_d2;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q <= '0; tail_q <= '0; count_q <= '0;
      v1_q <= '0; v2_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i] <= '0; imm_q[i] <= '0; pc_q[i] <= '0; dest_q[i] <= '0; cls_q[i] <= CLS_ALU;
        t1_q[i] <= '0; d1_q[i] <= '0; t2_q[i] <= '0; d2_q[i] <= '0;
      end
      alu_en_q <= 1'b0; br_en_q <= 1'b0; lsb_en_q <= 1'b0;
      out_op_q <= '0; out_imm_q <= '0; out_pc_q <= '0; out_dest_q <= '0;
      out_v1_q <= 1'b0; out_t1_q <= '0; out_d1_q <= '0;
      out_v2_q <= 1'b0; out_t2_q <= '0; out_d2_q <= '0;
    end else begin
      head_q <= head_d; tail_q <= tail_d; count_q <= count_d;
      op_q <= op_d; imm_q <= imm_d; pc_q <= pc_d; dest_q <= dest_d; cls_q <= cls_d;
      v1_q <= v1_d; t1_q <= t1_d; d1_q <= d1_d;
      v2_q <= v2_d; t2_q <= t2_d; d2_q <= d2_d;
      alu_en_q <= alu_en_d; br_en_q <= br_en_d; lsb_en_q <= lsb_en_d;
      out_op_q <= out_op_d; out_imm_q <= out_imm_d; out_pc_q <= out_pc_d; out_dest_q <= out_dest_d;
      out_v1_q <= out_v1_d; out_t1_q <= out_t1_d; out_d1_q <= out_d1_d;
      out_v2_q <= out_v2_d; out_t2_q <= out_t2_d; out_d2_q <= out_d2_d;
    end
  end

  assign dq.alu_enable     = alu_en_q;
  assign dq.br_enable      = br_en_q;
  assign dq.lsb_enable     = lsb_en_q;
  assign dq.out_op         = out_op_q;
  assign dq.out_imm        = out_imm_q;
  assign dq.out_pc         = out_pc_q;
  assign dq.out_dest_tag   = out_dest_q;
  assign dq.out_reg1_valid = out_v1_q;
  assign dq.out_reg1_tag   = out_t1_q;
  assign dq.out_reg1_data  = out_d1_q;
  assign dq.out_reg2_valid = out_v2_q;
  assign dq.out_reg2_tag   = out_t2_q;
  assign dq.out_reg2_data  = out_d2_q;
endmodule

// File: tb/tb_dispatch_queue.sv
// tb/tb_dispatch_queue.sv - directed self-checking bench for dispatch_queue
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clear_in;
  int   checks = 0;
  int   errors = 0;

  dispatch_queue_if #(.DATA_W(32), .TAG_W(4), .OP_W(6), .CDB_PORTS(2)) dq ();

  dispatch_queue #(.DEPTH(4), .DATA_W(32), .TAG_W(4), .OP_W(6), .CDB_PORTS(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in), .dq(dq));

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_en(input string tag, input logic [2:0] exp);
    chk(tag, {61'd0, dq.alu_enable, dq.br_enable, dq.lsb_enable}, {61'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_id(input logic [5:0] op, input logic [31:0] imm, input logic [31:0] pc,
                          input logic [3:0] dest, input logic v1, input logic [31:0] d1,
                          input logic [3:0] t1, input logic v2, input logic [31:0] d2,
                          input logic [3:0] t2);
    dq.id_valid = 1'b1; dq.id_op = op; dq.id_imm = imm; dq.id_pc = pc; dq.id_dest_tag = dest;
    dq.src1_valid = v1; dq.src1_data = d1; dq.src1_tag = t1;
    dq.src2_valid = v2; dq.src2_data = d2; dq.src2_tag = t2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0;
    dq.id_valid = 1'b0; dq.id_op = '0; dq.id_imm = '0; dq.id_pc = '0; dq.id_dest_tag = '0;
    dq.src1_valid = 1'b0; dq.src1_data = '0; dq.src1_tag = '0;
    dq.src2_valid = 1'b0; dq.src2_data = '0; dq.src2_tag = '0;
    dq.cdb_valid = '0; dq.cdb_tag = '0; dq.cdb_data = '0;
    dq.alu_full = 1'b0; dq.br_full = 1'b0; dq.lsb_full = 1'b0;

    #2;
    chk("rst_ready", dq.id_ready, 0);
    chk_en("rst_en", 3'b000);
    chk("rst_count", dut.count_q, 0);
    chk("rst_out_op", dq.out_op, 0);
    tick(); tick();
    rst_in = 1'b1;
    #1;
    chk("ready_after_rst", dq.id_ready, 1);

    // ADDI with ready operand: issues two edges after acceptance
    drive_id(6'(OP_ADDI), 32'd7, 32'h100, 4'd1, 1'b1, 32'd5, 4'd0, 1'b1, 32'd9, 4'd0);
    tick();
    dq.id_valid = 1'b0;
    chk_en("t1_not_yet", 3'b000);
    chk("t1_count", dut.count_q, 1);
    tick();
    chk_en("t1_alu", 3'b100);
    chk("t1_r1data", dq.out_reg1_data, 5);
    chk("t1_r1tag", dq.out_reg1_tag, 0);
    chk("t1_op", dq.out_op, OP_ADDI);
    chk("t1_dest", dq.out_dest_tag, 1);
    chk("t1_r2data", dq.out_reg2_data, 9);
    tick();
    chk_en("t1_one_cycle", 3'b000);

    // BEQ whose rs1 is woken on port 1 during the enqueue cycle
    drive_id(6'(OP_BEQ), 32'd0, 32'h104, 4'd2, 1'b0, 32'hdead, 4'd3, 1'b1, 32'd0, 4'd0);
    dq.cdb_valid = 2'b10; dq.cdb_tag = {4'd3, 4'd0}; dq.cdb_data = {32'h77, 32'h0};
    tick();
    dq.id_valid = 1'b0; dq.cdb_valid = 2'b00;
    tick();
    chk_en("t2_br", 3'b010);
    chk("t2_r1valid", dq.out_reg1_valid, 1);
    chk("t2_r1data", dq.out_reg1_data, 32'h77);
    chk("t2_r1tag", dq.out_reg1_tag, 0);

    // LSB full: LW blocks ADD behind it; LW woken while waiting (lowest port wins)
    dq.lsb_full = 1'b1;
    drive_id(6'(OP_LW), 32'd0, 32'h108, 4'd3, 1'b0, 32'd0, 4'd5, 1'b1, 32'd0, 4'd0);
    tick();
    drive_id(6'(OP_ADD), 32'd0, 32'h10c, 4'd4, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
    tick();
    dq.id_valid = 1'b0;
    dq.cdb_valid = 2'b11; dq.cdb_tag = {4'd5, 4'd5}; dq.cdb_data = {32'h66, 32'h55};
    tick();
    dq.cdb_valid = 2'b00;
    chk("t3_count", dut.count_q, 2);
    chk_en("t3_blocked", 3'b000);
    tick();
    chk_en("t3_stall", 3'b000);
    dq.lsb_full = 1'b0;
    tick();
    chk_en("t3_lsb", 3'b001);
    chk("t3_lw_op", dq.out_op, OP_LW);
    chk("t3_lw_r1", dq.out_reg1_data, 32'h55);
    tick();
    chk_en("t3_alu", 3'b100);
    chk("t3_add_op", dq.out_op, OP_ADD);
    tick();
    chk_en("t3_idle", 3'b000);
    chk("t3_empty", dut.count_q, 0);

    // Fill, simultaneous enqueue+issue at DEPTH-1, full blocks ready
    dq.alu_full = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      drive_id(6'(OP_ADD), 32'(k), 32'h200, 4'd5, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
      tick();
    end
    chk("t4_count3", dut.count_q, 3);
    chk("t4_tail3", dut.tail_q, 3);
    dq.alu_full = 1'b0;
    drive_id(6'(OP_ADD), 32'd4, 32'h200, 4'd5, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
    tick();
    chk("t4_count_same", dut.count_q, 3);
    chk("t4_tail_wrap", dut.tail_q, 0);
    chk_en("t4_issue1", 3'b100);
    chk("t4_imm1", dq.out_imm, 1);
    dq.alu_full = 1'b1;
    drive_id(6'(OP_ADD), 32'd5, 32'h200, 4'd5, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
    tick();
    chk("t4_count4", dut.count_q, 4);
    chk("t4_full_ready", dq.id_ready, 0);
    chk_en("t4_blocked", 3'b000);
    dq.alu_full = 1'b0;
    drive_id(6'(OP_ADD), 32'd6, 32'h200, 4'd5, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
    tick();
    chk("t4_no_enq_full", dut.count_q, 3);
    chk("t4_imm2", dq.out_imm, 2);
    chk("t4_ready_back", dq.id_ready, 1);
    dq.id_valid = 1'b0;
    for (int k = 3; k <= 5; k++) begin
      tick();
      chk("t4_order", dq.out_imm, 64'(k));
    end
    tick();
    chk_en("t4_drained", 3'b000);
    chk("t4_empty", dut.count_q, 0);

    // Flush beats enqueue and issue
    dq.alu_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_id(6'(OP_ADD), 32'd8, 32'h300, 4'd6, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
      tick();
    end
    dq.id_valid = 1'b0;
    chk("t5_count3", dut.count_q, 3);
    clear_in = 1'b1; dq.alu_full = 1'b0;
    drive_id(6'(OP_ADD), 32'd9, 32'h304, 4'd7, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
    #1;
    chk("t5_clear_ready", dq.id_ready, 0);
    tick();
    chk("t5_count0", dut.count_q, 0);
    chk("t5_head0", dut.head_q, 0);
    chk("t5_tail0", dut.tail_q, 0);
    chk_en("t5_no_en", 3'b000);
    clear_in = 1'b0; dq.id_valid = 1'b0;
    tick();
    chk_en("t5_dropped", 3'b000);
    chk("t5_still_empty", dut.count_q, 0);

    // Asynchronous reset in the middle of an issue
    drive_id(6'(OP_ADDI), 32'd1, 32'h400, 4'd8, 1'b1, 32'd5, 4'd0, 1'b1, 32'd0, 4'd0);
    tick();
    dq.id_valid = 1'b0;
    tick();
    chk_en("t6_pre", 3'b100);
    #2 rst_in = 1'b0;
    #1;
    chk_en("t6_async_en", 3'b000);
    chk("t6_async_r1", dq.out_reg1_data, 0);
    chk("t6_async_op", dq.out_op, 0);
    chk("t6_async_cnt", dut.count_q, 0);
    #1 rst_in = 1'b1;

    // rdy_in low freezes the queue, including CDB capture
    drive_id(6'(OP_ADDI), 32'd2, 32'h500, 4'd9, 1'b1, 32'd6, 4'd0, 1'b0, 32'd0, 4'd6);
    tick();
    rdy_in = 1'b0;
    drive_id(6'(OP_ADD), 32'd3, 32'h504, 4'd10, 1'b1, 32'd0, 4'd0, 1'b1, 32'd0, 4'd0);
    dq.cdb_valid = 2'b01; dq.cdb_tag = {4'd0, 4'd6}; dq.cdb_data = {32'h0, 32'h99};
    #1;
    chk("t6_rdy_ready", dq.id_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_frozen_cnt", dut.count_q, 1);
      chk_en("t6_frozen_en", 3'b000);
    end
    dq.cdb_valid = 2'b00; dq.id_valid = 1'b0; rdy_in = 1'b1;
    tick();
    chk_en("t6_resume", 3'b100);
    chk("t6_r1", dq.out_reg1_data, 6);
    chk("t6_r2valid", dq.out_reg2_valid, 0);
    chk("t6_r2tag", dq.out_reg2_tag, 6);
    chk("t6_r2data", dq.out_reg2_data, 0);
    tick();
    chk_en("t6_done", 3'b000);
    chk("t6_empty", dut.count_q, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
